// File: rtl/fp_norm_round.sv
// ============================================================================
//  fp_norm_round : multi-cycle normalize / round-to-nearest-even / saturate
//  stage that packs a single-precision {sign, exp[7:0], frac[22:0]} result.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fp_norm_round #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [8:0]  exp_in,
  input  logic [26:0] mant_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [7:0]  exp_out,
  output logic [22:0] mant_out,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inex
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] c_step = 5'(SHIFT_STEP);

  state_t      r_state;
  logic        r_sign;
  logic        r_ftz;
  logic [9:0]  r_exp;
  logic [26:0] r_mant;

  // Leading zeros of bits[25:0]; 26 when the field is all zero.
  function automatic logic [4:0] lzc26(input logic [25:0] v);
    logic [4:0] n;
    n = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (v[i]) n = 5'(25 - i);
    end
    return n;
  endfunction

  logic [4:0]  w_lzc;
  logic [4:0]  w_shift;
  logic [25:0] w_shl;
  logic [22:0] w_frac;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [23:0] w_frac_sum;
  logic [9:0]  w_exp_rnd;

  always_comb begin
    w_lzc      = lzc26(r_mant[25:0]);
    w_shift    = (w_lzc > c_step) ? c_step : w_lzc;
    w_shl      = r_mant[26:1] << w_shift;
    w_frac     = r_mant[24:2];
    w_guard    = r_mant[1];
    w_sticky   = r_mant[0];
    w_round_up = w_guard & (w_sticky | w_frac[0]);
    w_frac_sum = {1'b0, w_frac} + {23'd0, w_round_up};
    // A carry out of the fraction means the significand became 2.0.
    w_exp_rnd  = r_exp + {9'd0, w_frac_sum[23]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_sign    <= 1'b0;
      r_ftz     <= 1'b0;
      r_exp     <= 10'd0;
      r_mant    <= 27'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= 8'd0;
      mant_out  <= 23'd0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_inex <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign    <= sign_in;
            r_exp     <= {1'b0, exp_in};
            r_mant    <= mant_in;
            r_ftz     <= (exp_in == 9'd0);
            in_ready  <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_inex <= 1'b0;
            r_state   <= ST_NORM;
          end
        end

        ST_NORM: begin
          if (r_ftz) begin
            sign_out  <= r_sign;
            exp_out   <= 8'd0;
            mant_out  <= 23'd0;
            flag_unf  <= |r_mant;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end else if (r_mant[26]) begin
            r_mant  <= {1'b0, r_mant[26:2], r_mant[1] | r_mant[0]};
            r_exp   <= r_exp + 10'd1;
            r_state <= ST_ROUND;
          end else if (r_mant == 27'd0) begin
            sign_out  <= r_sign;
            exp_out   <= 8'd0;
            mant_out  <= 23'd0;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end else if (r_mant[25]) begin
            r_state <= ST_ROUND;
          end else if ({5'd0, w_shift} >= r_exp) begin
            sign_out  <= r_sign;
            exp_out   <= 8'd0;
            mant_out  <= 23'd0;
            flag_unf  <= 1'b1;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            // Sticky stays in bit 0; only carry..guard move.
            r_mant[26:1] <= w_shl;
            r_exp        <= r_exp - {5'd0, w_shift};
          end
        end

        ST_ROUND: begin
          sign_out  <= r_sign;
          flag_inex <= w_guard | w_sticky;
          if (w_exp_rnd >= 10'd255) begin
            exp_out   <= 8'hFF;
            mant_out  <= 23'd0;
            flag_ovf  <= 1'b1;
            flag_inex <= 1'b1;
          end else begin
            exp_out  <= w_exp_rnd[7:0];
            mant_out <= w_frac_sum[22:0];
          end
          out_valid <= 1'b1;
          r_state   <= ST_DONE;
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_round.sv
// ============================================================================
//  tb_fp_norm_round : directed-vector self-checking bench for fp_norm_round.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [8:0]  exp_in = 9'd0;
  logic [26:0] mant_in = 27'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] mant_out;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inex;

  int n_cmp = 0;
  int n_err = 0;

  fp_norm_round #(.SHIFT_STEP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inex (flag_inex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  task automatic check_result(input string tag, input logic e_sign, input logic [7:0] e_exp,
                              input logic [22:0] e_mant, input logic [2:0] e_flags);
    check({tag, ".sign"}, {31'd0, sign_out}, {31'd0, e_sign});
    check({tag, ".exp"},  {24'd0, exp_out},  {24'd0, e_exp});
    check({tag, ".mant"}, {9'd0, mant_out},  {9'd0, e_mant});
    check({tag, ".flags"}, {29'd0, flag_ovf, flag_unf, flag_inex}, {29'd0, e_flags});
  endtask

  // Issue one operand, measure edges from the handshake edge to out_valid.
  task automatic issue(input string tag, input logic s, input logic [8:0] e, input logic [26:0] m,
                       input int e_lat);
    int  lat;
    logic ready_leak;
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    sign_in  = s;
    exp_in   = e;
    mant_in  = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    lat        = 0;
    ready_leak = 1'b0;
    while (!out_valid && lat < 60) begin
      if (in_ready) ready_leak = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (in_ready) ready_leak = 1'b1;
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".busy"}, {31'd0, ready_leak}, 32'd0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drained"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset", {28'd0, out_valid, in_ready, exp_out == 8'd0, mant_out == 23'd0},
          {28'd0, 4'b0111});
    reset = 1'b1;
    @(negedge clk);
    check("post_reset", {27'd0, out_valid, in_ready, flag_ovf, flag_unf, flag_inex},
          {27'd0, 5'b01000});

    // 1.0 already normal
    issue("one", 1'b0, 9'd127, 27'h2000000, 2);
    check_result("one", 1'b0, 8'd127, 23'd0, 3'b000);
    drain("one");

    // carry path -> 2.0
    issue("two", 1'b0, 9'd127, 27'h4000000, 2);
    check_result("two", 1'b0, 8'd128, 23'd0, 3'b000);
    drain("two");

    // deep normalization: lzc 23 -> 6 shift cycles
    issue("deep", 1'b0, 9'd127, 27'h0000004, 8);
    check_result("deep", 1'b0, 8'd104, 23'd0, 3'b000);
    drain("deep");

    // ties-to-even: tie with even lsb stays, tie with odd lsb rounds up
    issue("rne_even", 1'b0, 9'd127, 27'h2000002, 2);
    check_result("rne_even", 1'b0, 8'd127, 23'd0, 3'b001);
    drain("rne_even");
    issue("rne_odd", 1'b1, 9'd127, 27'h2000006, 2);
    check_result("rne_odd", 1'b1, 8'd127, 23'd2, 3'b001);
    drain("rne_odd");

    // carry with guard/sticky folding into sticky: inexact, no round-up
    issue("carry_stk", 1'b0, 9'd10, 27'h4000003, 2);
    check_result("carry_stk", 1'b0, 8'd11, 23'd0, 3'b001);
    drain("carry_stk");

    // overflow via round-up wrap
    issue("ovf", 1'b1, 9'd254, 27'h3FFFFFE, 2);
    check_result("ovf", 1'b1, 8'd255, 23'd0, 3'b101);
    drain("ovf");

    // single left shift
    issue("shift1", 1'b0, 9'd127, 27'h1000000, 3);
    check_result("shift1", 1'b0, 8'd126, 23'd0, 3'b000);
    drain("shift1");

    // exact zero mantissa: zero result, sign kept, no flags
    issue("zero", 1'b1, 9'd100, 27'h0000000, 1);
    check_result("zero", 1'b1, 8'd0, 23'd0, 3'b000);
    drain("zero");

    // flush-to-zero input exponent
    issue("ftz", 1'b1, 9'd0, 27'h2000000, 1);
    check_result("ftz", 1'b1, 8'd0, 23'd0, 3'b010);
    drain("ftz");

    // underflow during normalization, then hold with out_ready low
    issue("unf", 1'b1, 9'd3, 27'h0000004, 1);
    check_result("unf", 1'b1, 8'd0, 23'd0, 3'b010);
    repeat (10) @(negedge clk);
    check("unf.hold_valid", {31'd0, out_valid}, 32'd1);
    check_result("unf.hold", 1'b1, 8'd0, 23'd0, 3'b010);
    drain("unf");

    // reset pulse mid-NORM discards the operation
    @(negedge clk);
    exp_in = 9'd127; mant_in = 27'h0000004; sign_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid.busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #2;
    check("mid.reset", {30'd0, out_valid, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("mid.idle", {30'd0, out_valid, in_ready}, 32'd1);

    // stage still works after the abort
    issue("after", 1'b0, 9'd127, 27'h2000000, 2);
    check_result("after", 1'b0, 8'd127, 23'd0, 3'b000);
    drain("after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
